// File: rtl/seq_arith_unit.sv
// seq_arith_unit: registered add/sub/shift/multiply unit with start/done handshake
module seq_arith_unit #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         carry,
  output logic         overflow,
  output logic         zero,
  output logic         negative
);
  localparam int SW = $clog2(N);
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [2:0] op_r;
  logic [N-1:0] a_r, b_r, res_nx;
  logic [2*N-1:0] mc, acc;
  logic [CW-1:0] cnt, k_in;
  logic [N:0] sum, diff;
  logic sc, sv, accept, fin, c_nx, v_nx, is_add, is_sub, is_asl, is_asr, is_mul;
  always_comb begin
    accept = start && state != RUN;
    fin = state == RUN && cnt == '0;
    state_nx = accept ? RUN : fin ? DONE : state == DONE ? IDLE : state;
    k_in = (CW'(b[SW-1:0]) > CW'(N)) ? CW'(N) : CW'(b[SW-1:0]);
    is_add = op_r == 3'b000;
    is_sub = op_r == 3'b001;
    is_asl = op_r == 3'b010;
    is_asr = op_r == 3'b011;
    is_mul = op_r == 3'b100;
    sum = {1'b0, a_r} + {1'b0, b_r};
    diff = {1'b0, a_r} - {1'b0, b_r};
    res_nx = is_add ? sum[N-1:0] : is_sub ? diff[N-1:0] : (is_asl || is_asr) ? a_r :
             is_mul ? acc[N-1:0] : '0;
    c_nx = is_add ? sum[N] : is_sub ? ~diff[N] : (is_asl || is_asr) ? sc :
           is_mul ? |acc[2*N-1:N] : 1'b0;
    v_nx = is_add ? (a_r[N-1] == b_r[N-1] && sum[N-1] != a_r[N-1]) :
           is_sub ? (a_r[N-1] != b_r[N-1] && diff[N-1] != a_r[N-1]) :
           is_asl ? sv : 1'b0;
  end
  assign busy = state == RUN;
  assign done = state == DONE;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      op_r <= '0;
      a_r <= '0;
      b_r <= '0;
      mc <= '0;
      acc <= '0;
      cnt <= '0;
      sc <= 1'b0;
      sv <= 1'b0;
      result <= '0;
      carry <= 1'b0;
      overflow <= 1'b0;
      zero <= 1'b0;
      negative <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op_r <= op;
        a_r <= a;
        b_r <= b;
        mc <= {{N{1'b0}}, a};
        acc <= '0;
        sc <= 1'b0;
        sv <= 1'b0;
        cnt <= (op == 3'b010 || op == 3'b011) ? k_in : op == 3'b100 ? CW'(N) : '0;
      end else if (state == RUN && cnt != '0) begin
        cnt <= cnt - CW'(1);
        // one step per cycle: a multiplier bit for MUL, one bit position for shifts
        if (is_mul) begin
          acc <= acc + (b_r[0] ? mc : '0);
          mc <= mc << 1;
          b_r <= b_r >> 1;
        end else if (is_asl) begin
          sc <= a_r[N-1];
          sv <= sv | (a_r[N-1] ^ a_r[N-2]);
          a_r <= a_r << 1;
        end else begin
          sc <= a_r[0];
          a_r <= {a_r[N-1], a_r[N-1:1]};
        end
      end
      if (fin) begin
        result <= res_nx;
        carry <= c_nx;
        overflow <= v_nx;
        zero <= res_nx == '0;
        negative <= res_nx[N-1];
      end
    end
  end
endmodule

// File: tb/tb_seq_arith_unit.sv
// tb_seq_arith_unit: randomized and directed checks of seq_arith_unit against an arithmetic model
module tb_seq_arith_unit;
  logic clk = 0, rst_n = 0, start = 0;
  logic [2:0] op = '0;
  logic [3:0] a = '0, b = '0, result;
  logic busy, done, carry, overflow, zero, negative;
  int ncmp = 0, nerr = 0, last_r = 0;
  seq_arith_unit #(.N(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .carry(carry),
    .overflow(overflow), .zero(zero), .negative(negative)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model(input int o, input int x, input int y,
                       output int r, output int c, output int v, output int l);
    int sx, sy, k, t;
    sx = x >= 8 ? x - 16 : x;
    sy = y >= 8 ? y - 16 : y;
    k = y % 4;
    r = 0; c = 0; v = 0; l = 1;
    case (o)
      0: begin t = x + y; r = t % 16; c = int'(t >= 16); v = int'(sx + sy > 7 || sx + sy < -8); end
      1: begin r = (x - y + 16) % 16; c = int'(x >= y); v = int'(sx - sy > 7 || sx - sy < -8); end
      2: begin
        t = sx * (1 << k);
        r = (x << k) % 16; c = k > 0 ? (x >> (4 - k)) & 1 : 0;
        v = int'(t > 7 || t < -8); l = 1 + k;
      end
      3: begin r = (sx >>> k) & 15; c = k > 0 ? (x >> (k - 1)) & 1 : 0; l = 1 + k; end
      4: begin t = x * y; r = t % 16; c = int'(t >= 16); l = 5; end
      default: ;
    endcase
  endtask
  task automatic run(input int o, input int x, input int y, input bit poke);
    int r, c, v, l, cyc;
    model(o, x, y, r, c, v, l);
    start = 1; op = 3'(o); a = 4'(x); b = 4'(y);
    @(posedge clk); #1;
    start = 0; op = 3'($urandom); a = 4'($urandom); b = 4'($urandom);
    chk("busy", 32'(busy), 1);
    cyc = 0;
    do begin
      start = poke && cyc == 1;
      @(posedge clk); #1; cyc++;
    end while (!done && cyc < 40);
    start = 0;
    chk("latency", cyc, l);
    chk("result", 32'(result), r);
    chk("carry", 32'(carry), c);
    chk("overflow", 32'(overflow), v);
    chk("zero", 32'(zero), int'(r == 0));
    chk("negative", 32'(negative), (r >> 3) & 1);
    last_r = r;
  endtask
  task automatic idle(input int g);
    repeat (g) begin
      @(posedge clk); #1;
      chk("hold_done", 32'(done), 0);
      chk("hold_result", 32'(result), last_r);
    end
  endtask
  initial begin
    int dn;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_flags", {28'b0, carry, overflow, zero, negative}, 0);
    rst_n = 1;
    idle(1);
    run(0, 4'b0111, 4'b1001, 0); idle(1);
    run(1, 4'b0011, 4'b0101, 0);
    run(1, 4'b1000, 4'b0001, 0);
    run(2, 4'b0101, 4'b0010, 0);
    run(3, 4'b1000, 4'b0011, 0);
    run(2, 4'b0110, 4'b0000, 0);
    run(4, 4'b0111, 4'b0110, 0);
    run(4, 4'b0011, 4'b0010, 0);
    run(7, 4'b1111, 4'b1111, 0);
    run(4, 4'b1101, 4'b1011, 1); idle(2);
    start = 1; op = 3'b100; a = 4'b1111; b = 4'b1111;
    @(posedge clk); #1;
    start = 0;
    repeat (2) @(posedge clk);
    #1; rst_n = 0;
    @(posedge clk); #1; rst_n = 1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_result", 32'(result), 0);
    dn = 0;
    repeat (8) begin @(posedge clk); #1; dn += int'(done); end
    chk("midrst_no_done", dn, 0);
    last_r = 0;
    repeat (200) begin
      run($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom));
      idle($urandom_range(0, 2));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
